// File: rtl/array_argmin_pkg.sv
// Shared types and elaboration helpers for the event-counter argmin array.
package array_argmin_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // On equal counts the lower channel index is reported.
  localparam bit TIE_LOW_IDX_WINS = 1'b1;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/argmin_node.sv
// One registered 2:1 argmin compare node; port a carries the lower-index candidate.
module argmin_node
  import array_argmin_pkg::*;
#(
  parameter int unsigned W   = 12,
  parameter int unsigned IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IDW-1:0] a_idx,
  input  logic [W-1:0]   a_cnt,
  input  logic [IDW-1:0] b_idx,
  input  logic [W-1:0]   b_cnt,
  output logic [IDW-1:0] win_idx,
  output logic [W-1:0]   win_cnt
);

  logic take_b;

  always_comb begin
    take_b = (b_cnt < a_cnt) || (!TIE_LOW_IDX_WINS && (b_cnt == a_cnt));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_idx <= '0;
      win_cnt <= '0;
    end else if (take_b) begin
      win_idx <= b_idx;
      win_cnt <= b_cnt;
    end else begin
      win_idx <= a_idx;
      win_cnt <= a_cnt;
    end
  end

endmodule

// File: rtl/array_argmin_pipe.sv
// N-channel event-counter array with a pipelined argmin tree (latency IDW),
// per-channel clear, saturate/wrap overflow and a registered saturation flag.
module array_argmin_pipe
  import array_argmin_pkg::*;
#(
  parameter int unsigned W    = 12,
  parameter int unsigned N    = 4,
  parameter mode_e       MODE = MODE_SAT,
  localparam int unsigned IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic [IDW-1:0] id,
  input  logic           clr,
  input  logic [IDW-1:0] clr_id,
  output logic [IDW-1:0] min_id,
  output logic [W-1:0]   min_cnt,
  output logic           min_vld,
  output logic           any_sat
);

  if (!is_pow2(int'(N)) || (N < 2) || (W < 2)) begin : g_param_check
    $error("array_argmin_pipe: N must be a power of two >= 2 and W >= 2");
  end

  logic [W-1:0]   cnt [N];
  logic           sat_now;
  logic [IDW-1:0] vld_sr;

  // Clear has priority over increment on the same channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (clr && (clr_id == IDW'(i))) begin
          cnt[i] <= '0;
        end else if (ce && (id == IDW'(i))) begin
          if ((MODE == MODE_SAT) && (cnt[i] == '1)) cnt[i] <= cnt[i];
          else                                      cnt[i] <= cnt[i] + W'(1);
        end
      end
    end
  end

  always_comb begin
    sat_now = 1'b0;
    for (int unsigned i = 0; i < N; i++) sat_now = sat_now | (cnt[i] == '1);
  end

  always_ff @(posedge clk) begin
    if (rst) any_sat <= 1'b0;
    else     any_sat <= (MODE == MODE_SAT) && sat_now;
  end

  // Heap layout: node k compares nodes 2k and 2k+1; leaves N..2N-1 are the counters.
  logic [IDW-1:0] nidx [1:2*N-1];
  logic [W-1:0]   ncnt [1:2*N-1];

  for (genvar l = 0; l < N; l++) begin : g_leaf
    assign nidx[N+l] = IDW'(l);
    assign ncnt[N+l] = cnt[l];
  end

  for (genvar k = 1; k < N; k++) begin : g_node
    argmin_node #(
      .W   (W),
      .IDW (IDW)
    ) u_node (
      .clk     (clk),
      .rst     (rst),
      .a_idx   (nidx[2*k]),
      .a_cnt   (ncnt[2*k]),
      .b_idx   (nidx[2*k+1]),
      .b_cnt   (ncnt[2*k+1]),
      .win_idx (nidx[k]),
      .win_cnt (ncnt[k])
    );
  end

  assign min_id  = nidx[1];
  assign min_cnt = ncnt[1];

  always_ff @(posedge clk) begin
    if (rst) vld_sr <= '0;
    else     vld_sr <= (vld_sr << 1) | IDW'(1);
  end

  assign min_vld = vld_sr[IDW-1];

endmodule

// File: tb/tb_array_argmin_pipe.sv
// Directed self-checking bench: four configurations of array_argmin_pipe.
module tb_array_argmin_pipe;
  import array_argmin_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ce, clr, ce8, clr8;
  logic [1:0] id, clr_id;
  logic [2:0] id8, clr_id8;

  logic [1:0]  a_id;  logic [11:0] a_cnt; logic a_vld, a_sat;
  logic [1:0]  b_id;  logic [3:0]  b_cnt; logic b_vld, b_sat;
  logic [1:0]  c_id;  logic [3:0]  c_cnt; logic c_vld, c_sat;
  logic [2:0]  d_id;  logic [11:0] d_cnt; logic d_vld, d_sat;

  int n_cmp = 0;
  int n_err = 0;

  array_argmin_pipe #(.W(12), .N(4), .MODE(MODE_SAT)) u_a (
    .clk(clk), .rst(rst), .ce(ce), .id(id), .clr(clr), .clr_id(clr_id),
    .min_id(a_id), .min_cnt(a_cnt), .min_vld(a_vld), .any_sat(a_sat));

  array_argmin_pipe #(.W(4), .N(4), .MODE(MODE_SAT)) u_b (
    .clk(clk), .rst(rst), .ce(ce), .id(id), .clr(clr), .clr_id(clr_id),
    .min_id(b_id), .min_cnt(b_cnt), .min_vld(b_vld), .any_sat(b_sat));

  array_argmin_pipe #(.W(4), .N(4), .MODE(MODE_WRAP)) u_c (
    .clk(clk), .rst(rst), .ce(ce), .id(id), .clr(clr), .clr_id(clr_id),
    .min_id(c_id), .min_cnt(c_cnt), .min_vld(c_vld), .any_sat(c_sat));

  array_argmin_pipe #(.W(12), .N(8), .MODE(MODE_SAT)) u_d (
    .clk(clk), .rst(rst), .ce(ce8), .id(id8), .clr(clr8), .clr_id(clr_id8),
    .min_id(d_id), .min_cnt(d_cnt), .min_vld(d_vld), .any_sat(d_sat));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ce = 1'b0; clr = 1'b0; ce8 = 1'b0; clr8 = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [1:0] ch, input int n);
    for (int i = 0; i < n; i++) begin
      ce = 1'b1; id = ch;
      tick();
    end
    ce = 1'b0;
  endtask

  task automatic pulse8(input logic [2:0] ch, input int n);
    for (int i = 0; i < n; i++) begin
      ce8 = 1'b1; id8 = ch;
      tick();
    end
    ce8 = 1'b0;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [1:0] seq2 [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};

  initial begin
    rst = 1'b1; ce = 1'b0; clr = 1'b0; id = '0; clr_id = '0;
    ce8 = 1'b0; clr8 = 1'b0; id8 = '0; clr_id8 = '0;
    tick(); tick();

    // reset state
    chk("rst_a_vld", a_vld, 0);
    chk("rst_a_id",  a_id,  0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_sat", a_sat, 0);
    chk("rst_d_vld", d_vld, 0);

    // test 1: min_vld rises IDW edges after release
    rst = 1'b0;
    tick();
    chk("t1_a_vld_e1", a_vld, 0);
    chk("t1_d_vld_e1", d_vld, 0);
    tick();
    chk("t1_a_vld_e2", a_vld, 1);
    chk("t1_a_id",     a_id,  0);
    chk("t1_a_cnt",    a_cnt, 0);
    chk("t1_d_vld_e2", d_vld, 0);
    tick();
    chk("t1_d_vld_e3", d_vld, 1);

    // test 2: counts 2,2,2,1 then all 2
    for (int i = 0; i < 7; i++) begin
      ce = 1'b1; id = seq2[i];
      tick();
    end
    idle(2);
    chk("t2_min_id",  a_id,  3);
    chk("t2_min_cnt", a_cnt, 1);
    pulse(2'd3, 1);
    idle(2);
    chk("t2_tie_id",  a_id,  0);
    chk("t2_tie_cnt", a_cnt, 2);

    // test 3: W=4 saturate vs wrap
    reset_all();
    pulse(2'd0, 15); pulse(2'd1, 15); pulse(2'd3, 15);
    pulse(2'd2, 16);
    idle(2);
    chk("t3_sat_id16",  b_id,  0);
    chk("t3_sat_cnt16", b_cnt, 15);
    chk("t3_sat_flag",  b_sat, 1);
    chk("t3_wrap_id16", c_id,  2);
    chk("t3_wrap_cnt16", c_cnt, 0);
    chk("t3_wrap_flag", c_sat, 0);
    pulse(2'd2, 4);
    idle(2);
    chk("t3_sat_id20",   b_id,  0);
    chk("t3_sat_cnt20",  b_cnt, 15);
    chk("t3_sat_flag20", b_sat, 1);
    chk("t3_wrap_id20",  c_id,  2);
    chk("t3_wrap_cnt20", c_cnt, 4);

    // test 4: clear vs increment
    reset_all();
    pulse(2'd0, 10); pulse(2'd2, 10); pulse(2'd3, 10); pulse(2'd1, 5);
    idle(2);
    chk("t4_pre_id",  a_id,  1);
    chk("t4_pre_cnt", a_cnt, 5);
    ce = 1'b1; id = 2'd1; clr = 1'b1; clr_id = 2'd1;
    tick();
    idle(2);
    chk("t4_same_id",  a_id,  1);
    chk("t4_same_cnt", a_cnt, 0);
    pulse(2'd1, 5);
    ce = 1'b1; id = 2'd1; clr = 1'b1; clr_id = 2'd2;
    tick();
    idle(2);
    chk("t4_diff_id",  a_id,  2);
    chk("t4_diff_cnt", a_cnt, 0);
    pulse(2'd2, 8);
    idle(2);
    chk("t4_inc_id",  a_id,  1);
    chk("t4_inc_cnt", a_cnt, 6);

    // test 5: N=8 load {9,7,7,3,8,3,5,6}, channel 3 written last
    pulse8(3'd0, 9); pulse8(3'd1, 7); pulse8(3'd2, 7); pulse8(3'd4, 8);
    pulse8(3'd5, 3); pulse8(3'd6, 5); pulse8(3'd7, 6); pulse8(3'd3, 3);
    tick();
    chk("t5_e1_id",  d_id,  3);
    chk("t5_e1_cnt", d_cnt, 1);
    tick();
    chk("t5_e2_cnt", d_cnt, 2);
    tick();
    chk("t5_e3_id",  d_id,  3);
    chk("t5_e3_cnt", d_cnt, 3);
    chk("t5_vld",    d_vld, 1);
    chk("t5_sat",    d_sat, 0);

    // test 6: reset while tree busy, ce held through reset
    ce8 = 1'b1; id8 = 3'd3;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("t6_rst_id",  d_id,  0);
    chk("t6_rst_cnt", d_cnt, 0);
    chk("t6_rst_vld", d_vld, 0);
    chk("t6_rst_sat", d_sat, 0);
    chk("t6_rst_avld", a_vld, 0);
    rst = 1'b0; ce8 = 1'b0;
    tick();
    chk("t6_e1_vld", d_vld, 0);
    chk("t6_e1_id",  d_id,  0);
    tick();
    chk("t6_e2_vld",  d_vld, 0);
    chk("t6_e2_avld", a_vld, 1);
    tick();
    chk("t6_e3_vld", d_vld, 1);
    chk("t6_e3_id",  d_id,  0);
    chk("t6_e3_cnt", d_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
